// File: rtl/design1_pkg.sv
// Shared constants, banner ROM and FSM state types for the UART boot/echo wrapper.
package design1_pkg;

    localparam int DEF_CLK_HZ     = 100_000_000;
    localparam int DEF_BAUD       = 230_400;
    localparam int DEF_BOOT_DELAY = 1000;
    localparam int BANNER_LEN     = 14;

    // Integer clocks per UART bit; truncation matches how the bit timer counts.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // "Hello World!\r\n"
    localparam logic [7:0] BANNER_ROM [BANNER_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
        8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A
    };

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: one byte per load, each bit held CLKS_PER_BIT clocks.
// Handshake: load_i is a valid strobe, !busy_o is ready; a byte transfers on a
// clock where both are high, and the start bit is driven on the next clock.
module uart_tx_core
    import design1_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       load_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       txd_o,
    output tx_state_e  state_o
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic        bit_end;

    assign bit_end = (cnt_q == BIT_LAST);
    assign state_o = state_q;

    // State and datapath registers; reset parks the line in IDLE (txd high).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Next state: walk START -> DATA x8 -> STOP, one bit time each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    state_d = TX_START;
                    data_d  = data_i;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs decoded from the registered state so reset forces txd high at once.
    always_comb begin
        txd_o  = 1'b1;
        done_o = 1'b0;
        busy_o = (state_q != TX_IDLE);
        case (state_q)
            TX_START: txd_o = 1'b0;
            TX_DATA:  txd_o = data_q[bit_q];
            TX_STOP: begin
                txd_o  = 1'b1;
                done_o = bit_end;
            end
            default: txd_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/design1_wrapper.sv
// FPGA-top stand-in: sends a boot banner once per reset, then echoes UART RX bytes.
module design1_wrapper
    import design1_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int BOOT_DELAY = DEF_BOOT_DELAY,
    parameter bit ECHO_EN    = 1'b1
) (
    input  logic clock,
    input  logic reset_rtl,
    output logic uart_rtl_txd,
    input  logic uart_rtl_rxd
);

    localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MID_CNT      = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] BOOT_LAST    = 16'(BOOT_DELAY - 1);
    localparam logic [3:0]  BANNER_LAST  = 4'(BANNER_LEN - 1);

    // TX side
    logic        tx_busy, tx_done, tx_load, tx_ready;
    logic [7:0]  tx_data;
    tx_state_e   tx_state;
    logic [15:0] boot_cnt_q;
    logic        boot_ok;
    logic [3:0]  banner_idx_q;
    logic        banner_last_q, banner_done_q;
    logic        ban_load, echo_load;

    // RX side
    logic [1:0]  rx_sync_q;
    logic        rx_s;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_wr;

    // Echo buffer (single entry)
    logic [7:0]  buf_q;
    logic        buf_full_q;

    // Loads are only offered while the transmitter reports IDLE.
    assign tx_ready  = !tx_busy && (tx_state == TX_IDLE);
    assign boot_ok   = (boot_cnt_q == BOOT_LAST);
    assign ban_load  = boot_ok && !banner_last_q && tx_ready;
    assign echo_load = banner_done_q && buf_full_q && tx_ready;
    assign tx_load   = ban_load || echo_load;
    assign tx_data   = ban_load ? BANNER_ROM[banner_idx_q] : buf_q;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i  (clock),
        .rst_ni (reset_rtl),
        .data_i (tx_data),
        .load_i (tx_load),
        .busy_o (tx_busy),
        .done_o (tx_done),
        .txd_o  (uart_rtl_txd),
        .state_o(tx_state)
    );

    // Boot delay and banner sequencer; banner done stays set until reset.
    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) begin
            boot_cnt_q    <= '0;
            banner_idx_q  <= '0;
            banner_last_q <= 1'b0;
            banner_done_q <= 1'b0;
        end else begin
            if (!boot_ok) boot_cnt_q <= boot_cnt_q + 16'd1;
            if (ban_load) begin
                if (banner_idx_q == BANNER_LAST) banner_last_q <= 1'b1;
                else                             banner_idx_q  <= banner_idx_q + 4'd1;
            end
            if (tx_done && banner_last_q) banner_done_q <= 1'b1;
        end
    end

    assign rx_s = rx_sync_q[1];

    // RX state, 2-FF synchronizer and datapath registers.
    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rtl_rxd};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: mid-bit sampling from a re-checked start bit; unknown levels never start a frame.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_s == 1'b0) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == MID_CNT) begin
                    rx_cnt_d = '0;
                    if (rx_s == 1'b0) rx_state_d = RX_DATA;
                    else              rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_CLEANUP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_CLEANUP: rx_state_d = RX_IDLE;
            default:    rx_state_d = RX_IDLE;
        endcase
    end

    // RX output: a byte is offered to the echo buffer only with a valid stop bit.
    always_comb begin
        rx_wr = 1'b0;
        if (ECHO_EN && rx_state_q == RX_STOP && rx_cnt_q == BIT_LAST) begin
            if (rx_s == 1'b1) rx_wr = 1'b1;
        end
    end

    // Echo buffer: drop new bytes while full; a same-clock read frees the slot for the new byte.
    always_ff @(posedge clock or negedge reset_rtl) begin
        if (!reset_rtl) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else if (rx_wr && (!buf_full_q || echo_load)) begin
            buf_q      <= rx_shift_q;
            buf_full_q <= 1'b1;
        end else if (echo_load) begin
            buf_full_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench for design1_wrapper: banner, frame timing, mid-frame reset, echo paths.
module tb_design1_wrapper;

    // The UART runs faster than the board default so the whole sequence stays short.
    localparam int TB_CLK_HZ = 100_000_000;
    localparam int TB_BAUD   = 2_000_000;
    localparam int CPB       = TB_CLK_HZ / TB_BAUD;
    localparam int BOOT      = 1000;
    localparam int FRAME     = 11 * CPB;

    logic clk;
    logic rst_n;
    logic txd;
    logic rxd;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    string      banner_s = "Hello World!\r\n";
    bit         model_full;

    // Monitor state
    bit         mon_busy;
    int         mon_cnt;
    int         mon_ferr;
    logic [7:0] mon_byte;

    design1_wrapper #(
        .CLK_HZ    (TB_CLK_HZ),
        .BAUD      (TB_BAUD),
        .BOOT_DELAY(BOOT),
        .ECHO_EN   (1'b1)
    ) dut (
        .clock       (clk),
        .reset_rtl   (rst_n),
        .uart_rtl_txd(txd),
        .uart_rtl_rxd(rxd)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-side 8N1 receiver on txd, sampling mid-bit; aborts a frame on reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
            mon_cnt  = 0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                if (mon_cnt / CPB == 0) begin
                    if (txd !== 1'b0) mon_busy = 1'b0;
                end else if (mon_cnt / CPB <= 8) begin
                    mon_byte[mon_cnt / CPB - 1] = txd;
                end else begin
                    if (txd === 1'b1) got_q.push_back(mon_byte);
                    else              mon_ferr++;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_banner();
        for (int i = 0; i < banner_s.len(); i++) exp_q.push_back(banner_s[i]);
    endtask

    // Echo buffer model: one slot, valid frames only, later arrivals lost while occupied.
    task automatic model_rx(input logic [7:0] d, input logic stop_v);
        if (stop_v == 1'b1 && !model_full) begin
            model_full = 1'b1;
            exp_q.push_back(d);
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    // Drive one frame on rxd; lat = clocks from stop-bit start to first txd low (-1 if none).
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int tail,
                              output int lat);
        logic [9:0] f;
        f   = {stop_v, d, 1'b0};
        lat = -1;
        for (int b = 0; b < 10; b++) begin
            rxd = f[b];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (b == 9 && lat < 0 && txd === 1'b0) lat = c;
            end
        end
        rxd = 1'b1;
        for (int c = 0; c < tail && lat < 0; c++) begin
            @(negedge clk);
            if (txd === 1'b0) lat = CPB + c;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        check("reset_txd", {31'd0, txd}, 32'd1);
        model_full = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int         cyc;
        int         lat;
        int         lows;
        int         w;
        logic [7:0] first_b;
        logic [9:0] frame;
        logic [7:0] d;

        // Phase A: rxd left undriven, banner and first-frame timing
        rst_n = 1'b0;
        mon_ferr = 0;
        repeat (10) @(negedge clk);
        do_reset(0);
        push_banner();

        cyc = 0;
        while (cyc < 3 * BOOT && txd !== 1'b0) begin
            @(negedge clk);
            cyc++;
        end
        check("boot_delay_in_window", {31'd0, (cyc >= BOOT - 1 && cyc <= BOOT + 1)}, 32'd1);

        first_b = banner_s[0];
        frame   = {1'b1, first_b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c % CPB == 0)       check("bit_first_clk", {31'd0, txd}, {31'd0, frame[c / CPB]});
            if (c % CPB == CPB - 1) check("bit_last_clk",  {31'd0, txd}, {31'd0, frame[c / CPB]});
            @(negedge clk);
        end

        wait_bytes(14, 15 * FRAME);
        repeat (CPB) @(negedge clk);
        lows = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (txd !== 1'b1) lows++;
            @(negedge clk);
        end
        check("idle_after_banner", lows, 0);
        compare_stream("banner_a");

        // Phase B: reset in the middle of banner byte 5
        rxd = 1'b1;
        do_reset(5);
        push_banner();
        wait_bytes(5, BOOT + 7 * FRAME);
        for (int c = 0; c < 2 * CPB && txd !== 1'b0; c++) @(negedge clk);
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("txd_high_on_reset", {31'd0, txd}, 32'd1);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        compare_stream("pre_reset");

        // Phase C: restart, overflow during banner
        do_reset(0);
        push_banner();
        wait_bytes(2, BOOT + 3 * FRAME);
        model_rx(8'h31, 1'b1);
        send_frame(8'h31, 1'b1, 0, lat);
        model_rx(8'h32, 1'b1);
        send_frame(8'h32, 1'b1, 0, lat);
        wait_bytes(15, 16 * FRAME);
        repeat (4 * FRAME) @(negedge clk);
        compare_stream("banner_overflow");
        model_full = 1'b0;

        // Glitches shorter than half a bit and a framing error must not echo
        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(2, CPB / 2 - 5);
            rxd = 1'b0;
            repeat (w) @(negedge clk);
            rxd = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
        model_rx(8'h55, 1'b0);
        send_frame(8'h55, 1'b0, 0, lat);
        repeat (3 * FRAME) @(negedge clk);
        compare_stream("reject");

        // Echo 0x41 with latency bound
        model_rx(8'h41, 1'b1);
        send_frame(8'h41, 1'b1, 2 * CPB, lat);
        check("echo_41_latency_ok", {31'd0, (lat >= 0 && lat < 3 * CPB)}, 32'd1);
        wait_bytes(1, 2 * FRAME);
        compare_stream("echo_41");
        model_full = 1'b0;

        // Random echo traffic
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 3 * CPB)) @(negedge clk);
            model_rx(d, 1'b1);
            send_frame(d, 1'b1, 2 * CPB, lat);
            check("echo_rand_latency_ok", {31'd0, (lat >= 0 && lat < 3 * CPB)}, 32'd1);
            wait_bytes(1, 2 * FRAME);
            compare_stream("echo_rand");
            model_full = 1'b0;
        end

        check("tx_frame_errors", mon_ferr, 0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
